program_out_tracer: RTL and testbench



---
 rtl/tracer_pkg.sv | 20 ++
 rtl/trace_fifo.sv | 64 ++++++
 rtl/program_out_tracer.sv | 142 ++++++++++++++
 tb/tb_program_out_tracer.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/tracer_pkg.sv
// Shared types and defaults for the program_out tracer.
// The FSM state encoding, default widths and the FIFO entry-width helper live here.
package tracer_pkg;

  typedef enum logic [1:0] {
    ARM  = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_e;

  localparam int DATA_W_DEF = 64;
  localparam int TS_W_DEF   = 16;
  localparam int DROP_W_DEF = 8;

  // Width of one FIFO entry: data alone, or data plus its timestamp.
  function automatic int entry_w(input int data_w, input int ts_w, input bit ts_en);
    return ts_en ? (data_w + ts_w) : data_w;
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// Synchronous show-ahead FIFO.
// The head entry is always presented on dout_o.
// A push while full is accepted only when a pop happens on the same edge.
module trace_fifo #(
  parameter int WIDTH = 80,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         din_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         dout_o,
  output logic                     empty_o,
  output logic                     full_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q;
  logic [AW-1:0]    rptr_q;
  logic [LW-1:0]    level_q;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (level_q == '0);
  assign full_o  = (level_q == LW'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign dout_o  = mem_q[rptr_q];
  assign level_o = level_q;

  // Storage: written on accepted pushes, never reset (pointers define validity).
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wptr_q] <= din_i;
    end
  end

  // Pointers and occupancy; reset discards all contents.
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      if (do_push) begin
        wptr_q <= wptr_q + AW'(1);
      end
      if (do_pop) begin
        rptr_q <= rptr_q + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
    end
  end

endmodule

// File: rtl/program_out_tracer.sv
// Records each new value of the computer's program_out bus into a show-ahead
// FIFO that a host drains through a valid/ready handshake.
// Build option: define TRACER_TIMESTAMP_EN to store a free-running cycle stamp
// with every entry; otherwise rd_stamp is tied to zero and entries are data only.
module program_out_tracer
  import tracer_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = 16,
  parameter int TS_W   = TS_W_DEF,
  parameter int DROP_W = DROP_W_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [DATA_W-1:0]      program_out,
  input  logic                   freeze,
  output logic                   rd_valid,
  input  logic                   rd_ready,
  output logic [DATA_W-1:0]      rd_data,
  output logic [TS_W-1:0]        rd_stamp,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow,
  output logic [DROP_W-1:0]      dropped
);

`ifdef TRACER_TIMESTAMP_EN
  localparam bit TS_EN = 1'b1;
`else
  localparam bit TS_EN = 1'b0;
`endif
  localparam int EW = entry_w(DATA_W, TS_W, TS_EN);

  state_e            state_q;
  state_e            state_d;
  logic [DATA_W-1:0] prev_q;
  logic              capture;
  logic              pop;
  logic              drop;
  logic              fifo_empty;
  logic              fifo_full;
  logic [EW-1:0]     fifo_din;
  logic [EW-1:0]     fifo_dout;
  logic              overflow_q;
  logic [DROP_W-1:0] dropped_q;

  function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
    return (v == {DROP_W{1'b1}}) ? v : v + DROP_W'(1);
  endfunction

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ARM;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: HOLD returns through ARM so the first post-freeze value is always taken.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ARM:     if (!freeze) state_d = RUN;
      RUN:     if (freeze)  state_d = HOLD;
      HOLD:    if (!freeze) state_d = ARM;
      default: state_d = ARM;
    endcase
  end

  // FSM output: capture decision for this cycle.
  always_comb begin
    capture = 1'b0;
    case (state_q)
      ARM:     capture = !freeze;
      RUN:     capture = !freeze && (program_out != prev_q);
      default: capture = 1'b0;
    endcase
  end

  assign pop  = rd_valid && rd_ready;
  assign drop = capture && fifo_full && !pop;

  // Change-detection reference; follows every capture, including dropped ones.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_q <= '0;
    end else if (capture) begin
      prev_q <= program_out;
    end
  end

  // Sticky overflow flag and saturating drop counter; cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow_q <= 1'b0;
      dropped_q  <= '0;
    end else if (drop) begin
      overflow_q <= 1'b1;
      dropped_q  <= sat_inc(dropped_q);
    end
  end

`ifdef TRACER_TIMESTAMP_EN
  logic [TS_W-1:0] ts_q;

  // Free-running cycle stamp; wraps naturally.
  always_ff @(posedge clk) begin
    if (reset) begin
      ts_q <= '0;
    end else begin
      ts_q <= ts_q + TS_W'(1);
    end
  end

  assign fifo_din = {ts_q, program_out};
  assign rd_stamp = rd_valid ? fifo_dout[DATA_W +: TS_W] : '0;
`else
  assign fifo_din = program_out;
  assign rd_stamp = '0;
`endif

  trace_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (capture),
    .din_i   (fifo_din),
    .pop_i   (pop),
    .dout_o  (fifo_dout),
    .empty_o (fifo_empty),
    .full_o  (fifo_full),
    .level_o (level)
  );

  assign rd_valid = !fifo_empty;
  assign rd_data  = rd_valid ? fifo_dout[DATA_W-1:0] : '0;
  assign overflow = overflow_q;
  assign dropped  = dropped_q;

endmodule

// File: tb/tb_program_out_tracer.sv
// Scoreboard bench for program_out_tracer: stimulus queues expected entries,
// a negedge monitor pops and compares them on every handshake.
`timescale 1ns/1ps
module tb_program_out_tracer;

`ifdef TRACER_TIMESTAMP_EN
  localparam bit TS_EN = 1'b1;
`else
  localparam bit TS_EN = 1'b0;
`endif

  typedef struct packed {
    logic [63:0] d;
    logic [15:0] s;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] program_out;
  logic        freeze;
  logic        rd_valid;
  logic        rd_ready;
  logic [63:0] rd_data;
  logic [15:0] rd_stamp;
  logic [4:0]  level;
  logic        overflow;
  logic [7:0]  dropped;

  exp_t sb[$];
  exp_t mon_e;
  int   passed = 0;
  int   total  = 0;

  program_out_tracer dut (
    .clk         (clk),
    .reset       (reset),
    .program_out (program_out),
    .freeze      (freeze),
    .rd_valid    (rd_valid),
    .rd_ready    (rd_ready),
    .rd_data     (rd_data),
    .rd_stamp    (rd_stamp),
    .level       (level),
    .overflow    (overflow),
    .dropped     (dropped)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
  endtask

  // Expected stamp for a capture made at cycle k after reset release.
  function automatic logic [15:0] stamp(input int k);
    return TS_EN ? 16'(k) : 16'h0;
  endfunction

  function automatic exp_t mk(input logic [63:0] d, input int k);
    exp_t e;
    e.d = d;
    e.s = stamp(k);
    return e;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int cycles);
    reset       = 1'b1;
    freeze      = 1'b0;
    rd_ready    = 1'b0;
    program_out = 64'h0;
    repeat (cycles) step();
    sb.delete();
    reset = 1'b0;
  endtask

  task automatic drain(input string tag);
    rd_ready = 1'b1;
    for (int i = 0; i < 64; i++) begin
      if (!rd_valid) break;
      step();
    end
    rd_ready = 1'b0;
    check({tag, "_drain_done"}, 64'(rd_valid), 64'h0);
    check({tag, "_sb_left"}, 64'(sb.size()), 64'h0);
    check({tag, "_level_end"}, 64'(level), 64'h0);
  endtask

  // Monitor: every accepted head entry must match the next expected entry.
  always @(negedge clk) begin
    if (!reset && rd_valid && rd_ready) begin
      if (sb.size() == 0) begin
        total++;
        $display("FAIL unexpected_pop: got data 0x%0h, required no entry", rd_data);
      end else begin
        mon_e = sb.pop_front();
        check("pop_data", rd_data, mon_e.d);
        check("pop_stamp", 64'(rd_stamp), 64'(mon_e.s));
      end
    end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Reset values
    do_reset(3);
    check("rst_valid", 64'(rd_valid), 64'h0);
    check("rst_level", 64'(level), 64'h0);
    check("rst_overflow", 64'(overflow), 64'h0);
    check("rst_dropped", 64'(dropped), 64'h0);
    check("rst_data", rd_data, 64'h0);
    check("rst_stamp", 64'(rd_stamp), 64'h0);

    // T1: constant value recorded exactly once
    do_reset(2);
    program_out = 64'h5;
    sb.push_back(mk(64'h5, 0));
    repeat (10) step();
    check("t1_level", 64'(level), 64'h1);
    check("t1_valid", 64'(rd_valid), 64'h1);
    check("t1_head", rd_data, 64'h5);
    drain("t1");

    // T2: change detection with a consumer always ready
    do_reset(2);
    rd_ready = 1'b1;
    sb.push_back(mk(64'h1, 0));
    sb.push_back(mk(64'h2, 2));
    sb.push_back(mk(64'h3, 3));
    program_out = 64'h1; step();
    program_out = 64'h1; step();
    program_out = 64'h2; step();
    program_out = 64'h3; step();
    program_out = 64'h3; step();
    repeat (4) step();
    drain("t2");

    // T3: overflow with 20 distinct values, consumer stalled
    do_reset(2);
    for (int k = 0; k < 16; k++) sb.push_back(mk(64'(k + 1), k));
    for (int k = 0; k < 20; k++) begin
      program_out = 64'(k + 1);
      step();
    end
    check("t3_level", 64'(level), 64'd16);
    check("t3_overflow", 64'(overflow), 64'h1);
    check("t3_dropped", 64'(dropped), 64'd4);
    check("t3_head_held", rd_data, 64'h1);

    // T4: full FIFO, capture and pop on the same edge
    program_out = 64'h99;
    rd_ready    = 1'b1;
    sb.push_back(mk(64'h99, 20));
    step();
    rd_ready = 1'b0;
    check("t4_level", 64'(level), 64'd16);
    check("t4_dropped", 64'(dropped), 64'd4);
    check("t4_new_head", rd_data, 64'h2);
    drain("t4");
    check("t4_overflow_sticky", 64'(overflow), 64'h1);
    check("t4_dropped_sticky", 64'(dropped), 64'd4);

    // T5: freeze suppresses captures; after unfreeze the FSM passes through ARM
    // (freeze low seen at k=6 leaves HOLD, ARM records the value at k=7)
    do_reset(2);
    sb.push_back(mk(64'hA, 0));
    sb.push_back(mk(64'hC, 7));
    program_out = 64'hA; step();
    freeze = 1'b1;
    program_out = 64'hA; step();
    program_out = 64'hB; step();
    program_out = 64'hB; step();
    program_out = 64'hC; step();
    program_out = 64'hC; step();
    freeze = 1'b0;
    repeat (5) step();
    check("t5_level", 64'(level), 64'd2);
    check("t5_overflow", 64'(overflow), 64'h0);
    drain("t5");

    // T6: mid-operation reset discards contents and restarts the stamp
    do_reset(2);
    for (int k = 0; k < 8; k++) begin
      program_out = 64'h100 + 64'(k);
      step();
    end
    check("t6_level_pre", 64'(level), 64'd8);
    reset = 1'b1;
    step();
    check("t6_rst_valid", 64'(rd_valid), 64'h0);
    check("t6_rst_level", 64'(level), 64'h0);
    check("t6_rst_overflow", 64'(overflow), 64'h0);
    sb.delete();
    reset = 1'b0;
    program_out = 64'h77;
    sb.push_back(mk(64'h77, 0));
    step();
    check("t6_level_post", 64'(level), 64'h1);
    check("t6_stamp_head", 64'(rd_stamp), 64'(stamp(0)));
    drain("t6");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
